// File: rtl/lcd_write_arbiter_if.sv
// Bus between the LCD word requesters, the SPI word writer and the arbiter.
// master: requester/writer side; slave: arbiter side.
interface lcd_write_arbiter_if;
  logic       init_done;
  logic       init_req;
  logic [8:0] init_data;
  logic       init_last;
  logic       init_ack;
  logic       char_req;
  logic [8:0] char_data;
  logic       char_last;
  logic       char_ack;
  logic       fill_req;
  logic [8:0] fill_data;
  logic       fill_last;
  logic       fill_ack;
  logic       wr_done;
  logic [8:0] spi_data;
  logic       en_write;
  logic       busy;
  logic [1:0] owner;
  logic       timeout_err;

  modport master (
    output init_done,
    output init_req, init_data, init_last,
    output char_req, char_data, char_last,
    output fill_req, fill_data, fill_last,
    output wr_done,
    input  init_ack, char_ack, fill_ack,
    input  spi_data, en_write,
    input  busy, owner, timeout_err
  );

  modport slave (
    input  init_done,
    input  init_req, init_data, init_last,
    input  char_req, char_data, char_last,
    input  fill_req, fill_data, fill_last,
    input  wr_done,
    output init_ack, char_ack, fill_ack,
    output spi_data, en_write,
    output busy, owner, timeout_err
  );
endinterface

// File: rtl/lcd_write_arbiter.sv
// Burst-locked arbiter sharing one LCD SPI word writer (init/char/fill).
// Ports: sys_clk, sys_rst_n, bus (slave: reqs in, acks/spi/status out).
module lcd_write_arbiter #(
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 12
) (
  input logic            sys_clk,
  input logic            sys_rst_n,
  lcd_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    HOLD
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_INIT = 2'd1;
  localparam logic [1:0] OWN_CHAR = 2'd2;
  localparam logic [1:0] OWN_FILL = 2'd3;

  localparam logic [CNT_W-1:0] CNT_END =
    CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [8:0]       spi_q, spi_d;
  logic             en_q, en_d;
  logic [2:0]       ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             rr_fill_q, rr_fill_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       win;
  logic             sel_req;
  logic [8:0]       sel_data;
  logic             sel_last;

  // rr_fill_q set means fill was not granted last
  always_comb begin
    win = OWN_NONE;
    unique case (1'b1)
      !bus.init_done && bus.init_req:
        win = OWN_INIT;
      bus.init_done && bus.char_req
        && bus.fill_req:
        win = rr_fill_q ? OWN_FILL
                        : OWN_CHAR;
      bus.init_done && bus.char_req
        && !bus.fill_req:
        win = OWN_CHAR;
      bus.init_done && !bus.char_req
        && bus.fill_req:
        win = OWN_FILL;
      default:
        win = OWN_NONE;
    endcase
  end

  always_comb begin
    sel_req  = 1'b0;
    sel_data = '0;
    sel_last = 1'b0;
    unique case (owner_q)
      OWN_INIT: begin
        sel_req  = bus.init_req;
        sel_data = bus.init_data;
        sel_last = bus.init_last;
      end
      OWN_CHAR: begin
        sel_req  = bus.char_req;
        sel_data = bus.char_data;
        sel_last = bus.char_last;
      end
      OWN_FILL: begin
        sel_req  = bus.fill_req;
        sel_data = bus.fill_data;
        sel_last = bus.fill_last;
      end
      default: begin
        sel_req  = 1'b0;
        sel_data = '0;
        sel_last = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    spi_d     = spi_q;
    en_d      = 1'b0;
    ack_d     = 3'b000;
    err_d     = err_q;
    rr_fill_d = rr_fill_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win != OWN_NONE) begin
          owner_d = win;
          state_d = SEND;
        end
      end
      SEND: begin
        spi_d  = sel_data;
        en_d   = 1'b1;
        last_d = sel_last;
        cnt_d  = '0;
        unique case (owner_q)
          OWN_INIT: ack_d = 3'b100;
          OWN_CHAR: ack_d = 3'b010;
          OWN_FILL: ack_d = 3'b001;
          default:  ack_d = 3'b000;
        endcase
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.wr_done) begin
          if (last_q) begin
            state_d = IDLE;
            owner_d = OWN_NONE;
            // init bursts leave the pointer alone
            if (owner_q == OWN_CHAR)
              rr_fill_d = 1'b1;
            else if (owner_q == OWN_FILL)
              rr_fill_d = 1'b0;
          end else begin
            state_d = HOLD;
          end
        end else if (cnt_q == CNT_END) begin
          err_d   = 1'b1;
          owner_d = OWN_NONE;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (sel_req)
          state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      spi_q     <= '0;
      en_q      <= 1'b0;
      ack_q     <= 3'b000;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      rr_fill_q <= 1'b0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      spi_q     <= spi_d;
      en_q      <= en_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      rr_fill_q <= rr_fill_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.spi_data    = spi_q;
  assign bus.en_write    = en_q;
  assign bus.init_ack    = ack_q[2];
  assign bus.char_ack    = ack_q[1];
  assign bus.fill_ack    = ack_q[0];
  assign bus.busy        = busy_q;
  assign bus.owner       = owner_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Bench for lcd_write_arbiter: per-cycle vector table plus burst sequences.
// Second instance (TIMEOUT=16) exercises the writer-stall abort.
module tb_lcd_write_arbiter;

  logic sys_clk;
  logic sys_rst_n;

  lcd_write_arbiter_if bus ();
  lcd_write_arbiter_if tbus ();

  lcd_write_arbiter dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus.slave)
  );

  lcd_write_arbiter #(
    .TIMEOUT (16),
    .CNT_W   (4)
  ) dut_t (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (tbus.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int viol = 0;

  logic wr_auto = 1'b0;
  logic wr_man = 1'b0;
  logic tb_wr = 1'b0;
  bit   auto_on = 1'b0;
  int   wr_dly = 20;

  assign bus.wr_done  = wr_auto | wr_man;
  assign tbus.wr_done = tb_wr;

  typedef struct packed {
    logic [1:0] own;
    logic [2:0] ack;
    logic [8:0] spi;
  } ev_t;

  ev_t log_q[$];

  logic [9:0] wbuf [4][8];

  typedef struct packed {
    logic       done;
    logic       ir;
    logic       cr;
    logic       fr;
    logic       wd;
    logic       en;
    logic [2:0] ack;
    logic [1:0] own;
    logic       busy;
    logic [8:0] spi;
  } vec_t;

  vec_t vecs [20];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h want 0x%0h",
                  nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    total_cnt++;
    $display("FAIL %s: bound expired", nm);
  endtask

  function automatic ev_t mk_ev(input logic [1:0] o,
                                input logic [8:0] d);
    ev_t e;
    e.own = o;
    e.spi = d;
    e.ack = (o == 2'd1) ? 3'b100 :
            (o == 2'd2) ? 3'b010 : 3'b001;
    return e;
  endfunction

  task automatic chk_ev(input string nm, input int i,
                        input logic [1:0] o,
                        input logic [8:0] d);
    if (i >= log_q.size()) begin
      total_cnt++;
      $display("FAIL %s: event %0d missing", nm, i);
    end else begin
      chk(nm, 32'(log_q[i]), 32'(mk_ev(o, d)));
    end
  endtask

  function automatic vec_t mk(
    input logic done, ir, cr, fr, wd, en,
    input logic [2:0] ack, input logic [1:0] own,
    input logic busy, input logic [8:0] spi);
    vec_t v;
    v.done = done; v.ir = ir; v.cr = cr;
    v.fr = fr; v.wd = wd; v.en = en;
    v.ack = ack; v.own = own; v.busy = busy;
    v.spi = spi;
    return v;
  endfunction

  // Auto writer model: wr_done wr_dly cycles after en_write.
  always begin
    tick();
    if (bus.en_write && auto_on) begin
      repeat (wr_dly) @(posedge sys_clk);
      #1;
      wr_auto = 1'b1;
      tick();
      wr_auto = 1'b0;
    end
  end

  // Event log plus pulse-shape checks on en_write/acks.
  always begin
    logic prev_en;
    logic [2:0] a;
    prev_en = 1'b0;
    forever begin
      tick();
      a = {bus.init_ack, bus.char_ack, bus.fill_ack};
      if (bus.en_write)
        log_q.push_back({bus.owner, a, bus.spi_data});
      if (a != 3'b000 && !bus.en_write) viol++;
      if (bus.en_write && prev_en) viol++;
      if (bus.en_write && a != mk_ev(bus.owner, 9'h0).ack)
        viol++;
      prev_en = bus.en_write;
    end
  end

  task automatic set_req(input int who, input logic r,
                         input logic [9:0] w);
    case (who)
      1: begin
        bus.init_req = r; bus.init_data = w[8:0];
        bus.init_last = w[9];
      end
      2: begin
        bus.char_req = r; bus.char_data = w[8:0];
        bus.char_last = w[9];
      end
      default: begin
        bus.fill_req = r; bus.fill_data = w[8:0];
        bus.fill_last = w[9];
      end
    endcase
  endtask

  function automatic logic get_ack(input int who);
    case (who)
      1: return bus.init_ack;
      2: return bus.char_ack;
      default: return bus.fill_ack;
    endcase
  endfunction

  task automatic drive(input int who, input int n,
                       input int gap_at, input int gap);
    bit ok;
    for (int k = 0; k < n; k++) begin
      if (k == gap_at) repeat (gap) tick();
      set_req(who, 1'b1, wbuf[who][k]);
      ok = 1'b0;
      for (int c = 0; c < 2000 && !ok; c++) begin
        tick();
        ok = get_ack(who);
      end
      set_req(who, 1'b0, wbuf[who][k]);
      if (!ok) begin
        fail_now($sformatf("ack_wait_%0d", who));
        return;
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      tick();
      ok = !bus.busy;
    end
    if (!ok) fail_now(nm);
  endtask

  task automatic clr_inputs();
    bus.init_done = 1'b0;
    bus.init_req = 1'b0; bus.init_data = '0;
    bus.init_last = 1'b0;
    bus.char_req = 1'b0; bus.char_data = '0;
    bus.char_last = 1'b0;
    bus.fill_req = 1'b0; bus.fill_data = '0;
    bus.fill_last = 1'b0;
    tbus.init_done = 1'b0;
    tbus.init_req = 1'b0; tbus.init_data = '0;
    tbus.init_last = 1'b0;
    tbus.char_req = 1'b0; tbus.char_data = '0;
    tbus.char_last = 1'b0;
    tbus.fill_req = 1'b0; tbus.fill_data = '0;
    tbus.fill_last = 1'b0;
    wr_man = 1'b0;
    tb_wr = 1'b0;
  endtask

  task automatic do_reset();
    clr_inputs();
    sys_rst_n = 1'b0;
    repeat (2) tick();
    sys_rst_n = 1'b1;
    tick();
    log_q.delete();
  endtask

  function automatic logic [31:0] outs();
    return {bus.spi_data, bus.en_write,
            bus.init_ack, bus.char_ack, bus.fill_ack,
            bus.busy, bus.owner, bus.timeout_err};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    bit ok;
    sys_rst_n = 1'b1;
    clr_inputs();
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("reset_outs", outs(), 32'h0);
    tick();
    sys_rst_n = 1'b1;
    tick();
    chk("post_reset_outs", outs(), 32'h0);

    // Per-cycle arbitration table (lasts all 1).
    vecs[0]  = mk(0,0,1,1,0, 0,3'b000,0,0,9'h000);
    vecs[1]  = mk(1,0,1,1,0, 0,3'b000,2,1,9'h000);
    vecs[2]  = mk(1,0,1,1,0, 1,3'b010,2,1,9'h141);
    vecs[3]  = mk(1,0,1,1,0, 0,3'b000,2,1,9'h141);
    vecs[4]  = mk(1,0,1,1,1, 0,3'b000,0,0,9'h141);
    vecs[5]  = mk(1,0,1,1,0, 0,3'b000,3,1,9'h141);
    vecs[6]  = mk(1,0,1,1,0, 1,3'b001,3,1,9'h1F0);
    vecs[7]  = mk(1,0,1,1,1, 0,3'b000,0,0,9'h1F0);
    vecs[8]  = mk(1,0,1,1,0, 0,3'b000,2,1,9'h1F0);
    vecs[9]  = mk(1,0,1,1,0, 1,3'b010,2,1,9'h141);
    vecs[10] = mk(1,0,1,1,1, 0,3'b000,0,0,9'h141);
    vecs[11] = mk(1,1,0,0,0, 0,3'b000,0,0,9'h141);
    vecs[12] = mk(1,1,1,0,0, 0,3'b000,2,1,9'h141);
    vecs[13] = mk(1,1,1,0,0, 1,3'b010,2,1,9'h141);
    vecs[14] = mk(1,1,0,0,0, 0,3'b000,2,1,9'h141);
    vecs[15] = mk(1,0,0,0,1, 0,3'b000,0,0,9'h141);
    vecs[16] = mk(1,0,0,0,1, 0,3'b000,0,0,9'h141);
    vecs[17] = mk(1,0,1,1,0, 0,3'b000,3,1,9'h141);
    vecs[18] = mk(1,0,1,1,0, 1,3'b001,3,1,9'h1F0);
    vecs[19] = mk(1,0,1,1,1, 0,3'b000,0,0,9'h1F0);

    bus.init_data = 9'h011; bus.init_last = 1'b1;
    bus.char_data = 9'h141; bus.char_last = 1'b1;
    bus.fill_data = 9'h1F0; bus.fill_last = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.init_done = vecs[i].done;
      bus.init_req  = vecs[i].ir;
      bus.char_req  = vecs[i].cr;
      bus.fill_req  = vecs[i].fr;
      wr_man        = vecs[i].wd;
      tick();
      chk($sformatf("vec%0d", i),
          {bus.en_write, bus.init_ack, bus.char_ack,
           bus.fill_ack, bus.owner, bus.busy,
           bus.spi_data},
          {vecs[i].en, vecs[i].ack, vecs[i].own,
           vecs[i].busy, vecs[i].spi});
    end

    // 3-word init burst, wr_done 20 cycles after each word.
    auto_on = 1'b1;
    do_reset();
    wbuf[1][0] = 10'h011;
    wbuf[1][1] = 10'h129;
    wbuf[1][2] = 10'h336;
    drive(1, 3, -1, 0);
    wait_idle("init_idle");
    chk("init_count", log_q.size(), 3);
    chk_ev("init_w0", 0, 2'd1, 9'h011);
    chk_ev("init_w1", 1, 2'd1, 9'h129);
    chk_ev("init_w2", 2, 2'd1, 9'h136);
    chk("init_owner_end", bus.owner, 0);

    // char/fill blocked until init_done.
    do_reset();
    wbuf[2][0] = 10'h341;
    wbuf[3][0] = 10'h3F0;
    fork
      drive(2, 1, -1, 0);
      drive(3, 1, -1, 0);
      begin
        repeat (100) tick();
        chk("blocked_pre_init", log_q.size(), 0);
        bus.init_done = 1'b1;
      end
    join
    wait_idle("post_init_idle");
    chk("post_init_count", log_q.size(), 2);
    chk_ev("post_init_0", 0, 2'd2, 9'h141);
    chk_ev("post_init_1", 1, 2'd3, 9'h1F0);

    // Continuous single-word requests alternate.
    log_q.delete();
    for (int k = 0; k < 3; k++) begin
      wbuf[2][k] = 10'h200 | 10'(9'h141 + 9'(k));
      wbuf[3][k] = 10'h200 | 10'(9'h1F1 + 9'(k));
    end
    fork
      drive(2, 3, -1, 0);
      drive(3, 3, -1, 0);
    join
    wait_idle("rr_idle");
    chk("rr_count", log_q.size(), 6);
    for (int k = 0; k < 3; k++) begin
      chk_ev($sformatf("rr_c%0d", k), 2 * k,
             2'd2, 9'(9'h141 + 9'(k)));
      chk_ev($sformatf("rr_f%0d", k), 2 * k + 1,
             2'd3, 9'(9'h1F1 + 9'(k)));
    end

    // 4-word fill burst locked against a waiting char.
    log_q.delete();
    wbuf[3][0] = 10'h02A;
    wbuf[3][1] = 10'h1A0;
    wbuf[3][2] = 10'h1A1;
    wbuf[3][3] = 10'h3A2;
    wbuf[2][0] = 10'h344;
    fork
      drive(3, 4, 1, 30);
      begin
        repeat (3) tick();
        drive(2, 1, -1, 0);
      end
    join
    wait_idle("lock_idle");
    chk("lock_count", log_q.size(), 5);
    chk_ev("lock_f0", 0, 2'd3, 9'h02A);
    chk_ev("lock_f1", 1, 2'd3, 9'h1A0);
    chk_ev("lock_f2", 2, 2'd3, 9'h1A1);
    chk_ev("lock_f3", 3, 2'd3, 9'h1A2);
    chk_ev("lock_c0", 4, 2'd2, 9'h144);

    // Writer stall on the TIMEOUT=16 instance.
    tbus.init_req = 1'b1;
    tbus.init_data = 9'h0AA;
    tbus.init_last = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      tick();
      ok = tbus.en_write;
    end
    if (!ok) fail_now("to_en_write");
    chk("to_ack", tbus.init_ack, 1);
    tbus.init_req = 1'b0;
    repeat (15) tick();
    chk("to_err_before",
        {tbus.timeout_err, tbus.busy}, 2'b01);
    tick();
    chk("to_err_set",
        {tbus.timeout_err, tbus.busy, tbus.owner},
        4'b1000);
    tbus.init_req = 1'b1;
    tbus.init_data = 9'h0BB;
    tick();
    tick();
    chk("to_next_word",
        {tbus.en_write, tbus.spi_data}, {1'b1, 9'h0BB});
    tbus.init_req = 1'b0;
    repeat (3) tick();
    tb_wr = 1'b1;
    tick();
    tb_wr = 1'b0;
    chk("to_next_done",
        {tbus.timeout_err, tbus.busy}, 2'b10);

    // Reset in WAIT of a multi-word burst.
    auto_on = 1'b0;
    repeat (30) tick();
    bus.init_done = 1'b1;
    bus.char_req = 1'b1;
    bus.char_data = 9'h155;
    bus.char_last = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      tick();
      ok = bus.en_write;
    end
    if (!ok) fail_now("rst_en_write");
    repeat (3) tick();
    chk("rst_pre_busy", bus.busy, 1);
    sys_rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", outs(), 32'h0);
    bus.char_req = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    tick();
    chk("rst_no_resume", {bus.busy, bus.owner}, 3'b000);
    bus.fill_req = 1'b1;
    bus.fill_data = 9'h1AB;
    bus.fill_last = 1'b1;
    tick();
    chk("rst_grant",
        {bus.en_write, bus.owner, bus.busy}, 4'b0111);
    tick();
    chk("rst_send",
        {bus.en_write, bus.fill_ack, bus.spi_data},
        {2'b11, 9'h1AB});
    bus.fill_req = 1'b0;
    repeat (2) tick();
    wr_man = 1'b1;
    tick();
    wr_man = 1'b0;
    tick();
    chk("rst_done", {bus.busy, bus.owner}, 3'b000);

    chk("pulse_shape", viol, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
